// File: rtl/linear_interpolator.sv
// linear_interpolator
//   Upsamples a signed sample stream by L = 2**LOG2L. Every sample accepted on
//   i_ce starts a burst of L output samples, one per clock and flagged by o_ce,
//   that ramp linearly from the previous sample (prev) to the new one (x).
//   The last sample of each burst is exactly x. A one-entry pending register
//   holds a sample that arrives while a burst is still running.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   i_ce        data_in valid this cycle
//   data_in     signed input sample (WIDTH bits)
//   data_out    signed interpolated sample, registered
//   o_ce        data_out valid this cycle, registered
//   o_busy      pending register full; another i_ce before it drains is dropped
//   o_overflow  one-cycle pulse: an input sample was dropped
module linear_interpolator #(
  parameter int WIDTH = 8,
  parameter int LOG2L = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             o_ce,
  output logic             o_busy,
  output logic             o_overflow
);

  // delta needs one extra bit; the product adds room for k (up to L) and a sign.
  localparam int DW = WIDTH + 1;
  localparam int PW = WIDTH + 2 + LOG2L;

  localparam logic [LOG2L:0] K_ONE  = {{LOG2L{1'b0}}, 1'b1};
  localparam logic [LOG2L:0] K_ZERO = {(LOG2L + 1){1'b0}};
  localparam logic [LOG2L:0] K_LAST = {1'b1, {LOG2L{1'b0}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [LOG2L:0]   k_r, k_s;
  logic [WIDTH-1:0] x_r, x_s;
  logic [WIDTH-1:0] prev_r, prev_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic             pend_v_r, pend_v_s;
  logic [WIDTH-1:0] dout_s;
  logic             ce_s;
  logic             ovf_s;

  logic signed [DW-1:0] delta_s;
  logic signed [PW-1:0] delta_ext_s;
  logic signed [PW-1:0] k_ext_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] interp_s;
  logic                 last_s;

  assign o_busy = pend_v_r;

  // Interpolation datapath: prev + floor(k*(x-prev) / L). The result always
  // lies between prev and x, so dropping the upper bits cannot wrap.
  always_comb begin
    delta_s     = $signed({x_r[WIDTH-1], x_r}) - $signed({prev_r[WIDTH-1], prev_r});
    delta_ext_s = {{(PW - DW){delta_s[DW-1]}}, delta_s};
    k_ext_s     = {{(PW - LOG2L - 1){1'b0}}, k_r};
    prod_s      = delta_ext_s * k_ext_s;
    interp_s    = $signed({{(PW - WIDTH){prev_r[WIDTH-1]}}, prev_r}) + (prod_s >>> LOG2L);
    last_s      = (k_r == K_LAST);
  end

  // Next-state and output decode for the burst sequencer and pending slot.
  always_comb begin
    state_s  = state_r;
    k_s      = k_r;
    x_s      = x_r;
    prev_s   = prev_r;
    pend_s   = pend_r;
    pend_v_s = pend_v_r;
    dout_s   = data_out;
    ce_s     = 1'b0;
    ovf_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_ce) begin
          x_s     = data_in;
          k_s     = K_ONE;
          state_s = RUN;
        end else begin
          k_s = K_ZERO;
        end
      end
      RUN: begin
        ce_s = 1'b1;
        if (last_s) begin
          dout_s = x_r;
          prev_s = x_r;
          k_s    = K_ONE;
          if (pend_v_r) begin
            // Pending sample starts the next burst; a sample arriving now
            // refills the slot it just vacated, so nothing is lost.
            x_s = pend_r;
            if (i_ce) begin
              pend_s   = data_in;
              pend_v_s = 1'b1;
            end else begin
              pend_v_s = 1'b0;
            end
          end else if (i_ce) begin
            x_s = data_in;
          end else begin
            k_s     = K_ZERO;
            state_s = IDLE;
          end
        end else begin
          dout_s = interp_s[WIDTH-1:0];
          k_s    = k_r + K_ONE;
          if (i_ce) begin
            if (!pend_v_r) begin
              pend_s   = data_in;
              pend_v_s = 1'b1;
            end else begin
              ovf_s = 1'b1;
            end
          end else begin
            ovf_s = 1'b0;
          end
        end
      end
      default: begin
        state_s  = IDLE;
        k_s      = K_ZERO;
        pend_v_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      k_r        <= K_ZERO;
      x_r        <= {WIDTH{1'b0}};
      prev_r     <= {WIDTH{1'b0}};
      pend_r     <= {WIDTH{1'b0}};
      pend_v_r   <= 1'b0;
      data_out   <= {WIDTH{1'b0}};
      o_ce       <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state_r    <= state_s;
      k_r        <= k_s;
      x_r        <= x_s;
      prev_r     <= prev_s;
      pend_r     <= pend_s;
      pend_v_r   <= pend_v_s;
      data_out   <= dout_s;
      o_ce       <= ce_s;
      o_overflow <= ovf_s;
    end
  end

endmodule

// File: tb/tb_linear_interpolator.sv
// tb_linear_interpolator
//   Directed-vector bench with two instances: dut_a (LOG2L=1, L=2) and
//   dut_b (LOG2L=2, L=4). Inputs change 1 time unit after a rising edge and
//   outputs are sampled 1 time unit after the following rising edge.
module tb_linear_interpolator;

  logic clk = 1'b0;
  logic reset;

  logic              ce_a, ce_b;
  logic signed [7:0] din_a, din_b;
  logic        [7:0] dout_a, dout_b;
  logic              oce_a, oce_b, busy_a, busy_b, ovf_a, ovf_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  linear_interpolator #(.WIDTH(8), .LOG2L(1)) dut_a (
    .clk(clk), .reset(reset), .i_ce(ce_a), .data_in(din_a),
    .data_out(dout_a), .o_ce(oce_a), .o_busy(busy_a), .o_overflow(ovf_a)
  );

  linear_interpolator #(.WIDTH(8), .LOG2L(2)) dut_b (
    .clk(clk), .reset(reset), .i_ce(ce_b), .data_in(din_b),
    .data_out(dout_b), .o_ce(oce_b), .o_busy(busy_b), .o_overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic ce, input int d);
    if (which == 0) begin
      ce_a  = ce;
      din_a = d[7:0];
    end else begin
      ce_b  = ce;
      din_b = d[7:0];
    end
  endtask

  function automatic logic signed [31:0] dout(input int which);
    return (which == 0) ? $signed(dout_a) : $signed(dout_b);
  endfunction

  function automatic logic signed [31:0] oce(input int which);
    return (which == 0) ? {31'd0, oce_a} : {31'd0, oce_b};
  endfunction

  task automatic exp_out(input int which, input string tag, input int val);
    chk($sformatf("%s data", tag), dout(which), val);
    chk($sformatf("%s o_ce", tag), oce(which), 1);
  endtask

  task automatic reset_all();
    reset = 1'b1;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  int s1 [6]  = '{10, -20, 30, -127, 127, -60};
  // 30 -> -127 midpoint is 30 + floor(-157/2) = -49.
  int e1 [12] = '{5, 10, -5, -20, 5, 30, -49, -127, 0, 127, 33, -60};
  int e2 [4]  = '{50, 0, -50, -100};
  int e3 [4]  = '{-65, -1, 63, 127};
  int e4 [4]  = '{2, 4, 6, 8};

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    repeat (3) step();
    reset = 1'b0;
    step();
    step();

    // Reset state on both instances.
    chk("rst a data", dout(0), 0);
    chk("rst a o_ce", oce(0), 0);
    chk("rst a busy", {31'd0, busy_a}, 0);
    chk("rst a ovf",  {31'd0, ovf_a}, 0);
    chk("rst b data", dout(1), 0);
    chk("rst b o_ce", oce(1), 0);
    chk("rst b busy", {31'd0, busy_b}, 0);
    chk("rst b ovf",  {31'd0, ovf_b}, 0);

    // L=2, one input every 2 cycles: continuous output.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, s1[i]);
      step();
      if (i == 0) chk("t1 latency o_ce", oce(0), 0);
      else        exp_out(0, $sformatf("t1[%0d]", 2 * i - 1), e1[2 * i - 1]);
      drive(0, 1'b0, 0);
      step();
      exp_out(0, $sformatf("t1[%0d]", 2 * i), e1[2 * i]);
    end
    step();
    exp_out(0, "t1[11]", e1[11]);
    step();
    chk("t1 idle o_ce", oce(0), 0);
    chk("t1 idle hold", dout(0), -60);

    // L=2, inputs 1,2,3,4 on consecutive cycles: 2 parks in pending, 3 refills
    // pending on the last cycle, 4 is dropped.
    reset_all();
    drive(0, 1'b1, 1);
    step();
    drive(0, 1'b1, 2);
    step();
    exp_out(0, "t2[0]", 0);
    chk("t2 busy0", {31'd0, busy_a}, 1);
    drive(0, 1'b1, 3);
    step();
    exp_out(0, "t2[1]", 1);
    chk("t2 busy1", {31'd0, busy_a}, 1);
    chk("t2 ovf1", {31'd0, ovf_a}, 0);
    drive(0, 1'b1, 4);
    step();
    exp_out(0, "t2[2]", 1);
    chk("t2 ovf2", {31'd0, ovf_a}, 1);
    drive(0, 1'b0, 0);
    step();
    exp_out(0, "t2[3]", 2);
    chk("t2 ovf3", {31'd0, ovf_a}, 0);
    chk("t2 busy3", {31'd0, busy_a}, 0);
    step();
    exp_out(0, "t2[4]", 2);
    step();
    exp_out(0, "t2[5]", 3);
    step();
    chk("t2 idle o_ce", oce(0), 0);

    // L=4, 100 then -100.
    reset_all();
    drive(1, 1'b1, 100);
    step();
    drive(1, 1'b0, 0);
    step(); exp_out(1, "t3[0]", 25);
    step(); exp_out(1, "t3[1]", 50);
    step(); exp_out(1, "t3[2]", 75);
    drive(1, 1'b1, -100);
    step(); exp_out(1, "t3[3]", 100);
    drive(1, 1'b0, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      exp_out(1, $sformatf("t3[%0d]", 4 + j), e2[j]);
    end
    step();
    chk("t3 idle o_ce", oce(1), 0);
    chk("t3 idle hold", dout(1), -100);

    // L=4, extremes -128 then 127 from prev=0.
    reset_all();
    drive(1, 1'b1, -128);
    step();
    drive(1, 1'b0, 0);
    step(); exp_out(1, "t4[0]", -32);
    step(); exp_out(1, "t4[1]", -64);
    step(); exp_out(1, "t4[2]", -96);
    drive(1, 1'b1, 127);
    step(); exp_out(1, "t4[3]", -128);
    drive(1, 1'b0, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      exp_out(1, $sformatf("t4[%0d]", 4 + j), e3[j]);
    end
    step();
    chk("t4 idle o_ce", oce(1), 0);

    // L=4, reset on the 2nd burst cycle with a sample pending.
    reset_all();
    drive(1, 1'b1, 50);
    step();
    drive(1, 1'b1, 40);
    step();
    exp_out(1, "t5[0]", 12);
    chk("t5 busy", {31'd0, busy_b}, 1);
    drive(1, 1'b0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5 rst o_ce", oce(1), 0);
    chk("t5 rst data", dout(1), 0);
    chk("t5 rst busy", {31'd0, busy_b}, 0);
    drive(1, 1'b1, 8);
    step();
    chk("t5 latency o_ce", oce(1), 0);
    drive(1, 1'b0, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      exp_out(1, $sformatf("t5[%0d]", 1 + j), e4[j]);
    end
    step();
    chk("t5 idle o_ce", oce(1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
